// File: rtl/decoder_grant_arbiter.sv
// Round-robin arbiter for four clients sharing one 2-to-4 decoded resource.
// Grants are held until release, revoke or hold timeout, with a one-cycle gap.
module decoder_grant_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  localparam bit       TMO_EN = (MAX_HOLD != 0);
  localparam int       LAST_I = TMO_EN ? int'(MAX_HOLD) - 1 : 0;
  localparam logic [7:0] LAST = 8'(LAST_I);

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] gnt_q, gnt_d;
  logic       tmo_q, tmo_d;

  logic [1:0] winner;
  logic [1:0] scan;
  logic       found;
  logic       holder_req;
  logic       expire;
  logic [1:0] idx_nxt;
  logic [7:0] cnt_inc;

  // First requester at or after the pointer, wrapping mod 4.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    scan   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      scan = ptr_q + 2'(k);
      if (!found && req[scan]) begin
        winner = scan;
        found  = 1'b1;
      end
    end
  end

  assign holder_req = req[idx_q];
  assign expire     = TMO_EN && (cnt_q == LAST);
  assign idx_nxt    = idx_q + 2'd1;
  assign cnt_inc    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      idx_q   <= 2'd0;
      cnt_q   <= 8'd0;
      gnt_q   <= 4'd0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && found) begin
          state_d = GRANT;
          idx_d   = winner;
          cnt_d   = 8'd0;
        end
      end
      GRANT: begin
        priority case (1'b1)
          !enable: begin
            state_d = IDLE;
          end
          !holder_req: begin
            state_d = IDLE;
            ptr_d   = idx_nxt;
          end
          expire: begin
            state_d = IDLE;
            ptr_d   = idx_nxt;
            tmo_d   = 1'b1;
          end
          default: begin
            cnt_d = cnt_inc;
          end
        endcase
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: one-hot decode, only while a grant is pending.
  always_comb begin
    gnt_d = 4'd0;
    if (state_d == GRANT) begin
      gnt_d = 4'b0001 << idx_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = (state_q == GRANT);
  assign timeout   = tmo_q;

endmodule

// File: tb/tb_decoder_grant_arbiter.sv
// Scoreboard bench: two arbiters (MAX_HOLD=4 and 0) against a per-cycle
// behavioural model of the grant rules.
module tb_decoder_grant_arbiter;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
    logic       tmo;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [3:0] req;

  logic [3:0] gnt_a, gnt_b;
  logic [1:0] idx_a, idx_b;
  logic       vld_a, vld_b;
  logic       tmo_a, tmo_b;

  int checks = 0;
  int errors = 0;

  exp_t qa[$];
  exp_t qb[$];

  // Model state: holder is -1 when no grant; held counts grant cycles.
  int holder[2];
  int ptr_m[2];
  int held[2];
  int last[2];
  int mh[2];

  decoder_grant_arbiter #(.MAX_HOLD(4)) dut_a (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .req(req),
    .gnt(gnt_a),
    .gnt_idx(idx_a),
    .gnt_valid(vld_a),
    .timeout(tmo_a)
  );

  decoder_grant_arbiter #(.MAX_HOLD(0)) dut_b (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .req(req),
    .gnt(gnt_b),
    .gnt_idx(idx_b),
    .gnt_valid(vld_b),
    .timeout(tmo_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t model_step(input int m, input logic r,
                                      input logic e, input logic [3:0] q);
    exp_t x;
    bit   t;
    t = 1'b0;
    if (r) begin
      holder[m] = -1;
      ptr_m[m]  = 0;
      held[m]   = 0;
      last[m]   = 0;
    end else if (holder[m] < 0) begin
      if (e) begin
        for (int k = 0; k < 4; k++) begin
          int c;
          c = (ptr_m[m] + k) % 4;
          if (holder[m] < 0 && q[c]) begin
            holder[m] = c;
            last[m]   = c;
            held[m]   = 1;
          end
        end
      end
    end else if (!e) begin
      holder[m] = -1;
    end else if (!q[holder[m]]) begin
      ptr_m[m]  = (holder[m] + 1) % 4;
      holder[m] = -1;
    end else if (mh[m] > 0 && held[m] == mh[m]) begin
      ptr_m[m]  = (holder[m] + 1) % 4;
      holder[m] = -1;
      t = 1'b1;
    end else begin
      held[m] = held[m] + 1;
    end
    x.gnt = (holder[m] >= 0) ? 4'(1 << holder[m]) : 4'd0;
    x.idx = 2'(last[m]);
    x.vld = (holder[m] >= 0);
    x.tmo = t;
    return x;
  endfunction

  task automatic drive(input logic r, input logic e, input logic [3:0] q);
    @(negedge clk);
    reset  = r;
    enable = e;
    req    = q;
    qa.push_back(model_step(0, r, e, q));
    qb.push_back(model_step(1, r, e, q));
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares each registered output set against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        cmp("a.gnt", int'(gnt_a), int'(e.gnt));
        cmp("a.gnt_idx", int'(idx_a), int'(e.idx));
        cmp("a.gnt_valid", int'(vld_a), int'(e.vld));
        cmp("a.timeout", int'(tmo_a), int'(e.tmo));
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        cmp("b.gnt", int'(gnt_b), int'(e.gnt));
        cmp("b.gnt_idx", int'(idx_b), int'(e.idx));
        cmp("b.gnt_valid", int'(vld_b), int'(e.vld));
        cmp("b.timeout", int'(tmo_b), int'(e.tmo));
      end
    end
  end

  initial begin
    logic [3:0] r;
    mh[0] = 4;
    mh[1] = 0;
    for (int m = 0; m < 2; m++) begin
      holder[m] = -1;
      ptr_m[m]  = 0;
      held[m]   = 0;
      last[m]   = 0;
    end
    reset  = 1'b1;
    enable = 1'b1;
    req    = 4'b1111;

    // Reset with all requests pending, then first grant.
    drive(1, 1, 4'b1111);
    drive(1, 1, 4'b1111);
    drive(0, 1, 4'b1111);

    // Rotation: holder drops its request for one cycle after 3 grant cycles.
    for (int i = 0; i < 24; i++) begin
      if (holder[1] >= 0 && held[1] == 3) begin
        drive(0, 1, 4'b1111 & ~4'(1 << holder[1]));
      end else begin
        drive(0, 1, 4'b1111);
      end
    end

    // Timeout on a single long-held request.
    drive(1, 1, 4'b0000);
    for (int i = 0; i < 14; i++) drive(0, 1, 4'b0100);

    // Skip and wrap: client 2 releases, then 0 wins, then 1.
    drive(0, 1, 4'b0000);
    drive(0, 1, 4'b0000);
    drive(0, 1, 4'b0100);
    drive(0, 1, 4'b0100);
    drive(0, 1, 4'b0000);
    drive(0, 1, 4'b0011);
    drive(0, 1, 4'b0011);
    drive(0, 1, 4'b0010);
    drive(0, 1, 4'b0010);
    drive(0, 1, 4'b0010);

    // Revoke during a grant to client 1.
    drive(0, 1, 4'b0010);
    drive(0, 0, 4'b0010);
    drive(0, 0, 4'b0010);
    drive(0, 0, 4'b0010);
    drive(0, 1, 4'b0010);
    drive(0, 1, 4'b0010);
    drive(0, 1, 4'b0000);

    // Mid-grant reset, then ptr back to 0.
    drive(0, 1, 4'b0000);
    for (int i = 0; i < 7; i++) drive(0, 1, 4'b0100);
    drive(1, 1, 4'b0100);
    drive(0, 1, 4'b0101);
    drive(0, 1, 4'b0101);
    drive(0, 1, 4'b0000);

    // Long hold pushes the hold counter into saturation.
    drive(0, 1, 4'b0000);
    for (int i = 0; i < 300; i++) drive(0, 1, 4'b1000);
    drive(0, 1, 4'b0000);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r = 4'($urandom);
      if (holder[1] >= 0 && ($urandom % 8) != 0) r[holder[1]] = 1'b1;
      drive(($urandom % 97) == 0, ($urandom % 10) != 0, r);
    end

    @(posedge clk);
    #2;
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending expected 0",
               qa.size(), qb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_grant_arbiter.md
# decoder_grant_arbiter

Four-requester round-robin arbiter that shares one 2-to-4 decoded resource (e.g. a decoder-selected bank or output line) among four clients. It selects one requester, holds the grant until release or timeout, and drives the 2-bit select plus decoder enable and the decoded one-hot grant. It sits between the requesting clients and the decoder-driven resource, and sequences access with a break-before-make gap.

## Interface
- MAX_HOLD, default 16: maximum grant length in cycles; legal 0..255; 0 disables the timeout.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  arbiter enable; low revokes any grant and blocks new grants.
- req  input  4  request lines; req[i] held high while client i wants or uses the resource.
- gnt  output  4  registered one-hot grant; all zero when no grant.
- gnt_idx  output  2  registered index of the granted client (decoder select A/B).
- gnt_valid  output  1  registered; high while a grant is active (decoder enable).
- timeout  output  1  registered one-cycle pulse on a forced release.

## Operation
- State: IDLE or GRANT. Internal: round-robin pointer ptr[1:0] and hold counter cnt[7:0].
- gnt is the decode of gnt_idx gated by gnt_valid. gnt is never non-zero while gnt_valid=0.
- IDLE, enable=1, req!=0: the winner is the first i with req[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4). Next state is GRANT. gnt_idx=winner, gnt_valid=1, cnt=0.
- IDLE, enable=0 or req=0: stay in IDLE. Outputs stay zero and ptr is unchanged.
- Each GRANT cycle is evaluated in priority order:
  1. enable=0 (revoke): next state IDLE, gnt_valid=0. ptr is unchanged and timeout stays 0.
  2. req[gnt_idx]=0 (release): next state IDLE, gnt_valid=0, ptr=gnt_idx+1 (mod 4).
  3. MAX_HOLD!=0 and cnt==MAX_HOLD-1 with request still high (timeout): next state IDLE, gnt_valid=0, ptr=gnt_idx+1, timeout=1 for exactly one cycle.
  4. Otherwise: stay in GRANT and increment cnt. cnt saturates at 255.
- Requests from clients other than the holder are ignored during GRANT. Grants are never pre-empted except by revoke or timeout.
- gnt_idx keeps its last value when gnt_valid=0. Consumers must qualify gnt_idx with gnt_valid.
- Reset values: state IDLE, ptr=0, cnt=0, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0. Reset wins over all other inputs, including mid-grant: the grant drops at the edge where reset is sampled.

## Timing
- Request to grant latency: req sampled high in IDLE at edge N gives gnt valid after edge N (visible in cycle N+1). This is one cycle.
- Release latency: req[gnt_idx] sampled low at edge N gives gnt=0 after edge N.
- Break-before-make: every grant end is followed by at least one cycle with gnt=0, even when other requests are pending. Back-to-back grants are therefore spaced by one idle cycle.
- Minimum grant length is 1 cycle (release seen in the first GRANT cycle).
- Maximum grant length is exactly MAX_HOLD cycles when MAX_HOLD>0.
- timeout is high in the first IDLE cycle after a forced release, coincident with gnt=0.
- Simultaneous release and timeout in the same cycle is treated as a release: no timeout pulse.
- Simultaneous revoke and timeout is treated as a revoke: ptr is unchanged and there is no timeout pulse.
- Pointer wrap: a grant to client 3 ending by release or timeout sets ptr=0.

## Test plan
- Reset/idle: assert reset for 2 cycles with req=4'b1111 and enable=1. Required: gnt=0, gnt_valid=0, timeout=0 during reset. Release reset, then gnt=4'b0001 one cycle later.
- Round-robin rotation: hold req=4'b1111, MAX_HOLD=0, and each holder drops its req for one cycle after 3 grant cycles. Required grant sequence 0001, 0010, 0100, 1000, 0001, with one gnt=0 cycle between each grant.
- Timeout: MAX_HOLD=4, req=4'b0100 held. Required: gnt=0100 for exactly 4 cycles, then gnt=0 with timeout=1 for 1 cycle, then gnt=0100 again.
- Skip and wrap: ptr=3 (after client 2 releases), req=4'b0011. Required: gnt=0001. After its release, gnt=0010.
- Revoke: during a grant to client 1, drop enable for 3 cycles. Required: gnt=0 one cycle later with no timeout pulse. With req unchanged and enable restored, client 1 is regranted because ptr is unchanged.
- Mid-grant reset: during a grant to client 2 at cnt=5, assert reset for 1 cycle. Required: gnt=0 after that edge, ptr=0, and the next grant with req=4'b0101 goes to client 0.
